// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed driver for a 4-digit common-anode 7-segment
//               display showing mm:ss from one of two digit sets.
//               A prescaler produces one "tick" every REFRESH_DIV clocks. Each
//               tick advances the digit slot and registers the new anode,
//               cathode and decimal-point values. The digits are captured once
//               per frame so that a frame never shows a mix of old and new
//               values. Leading-zero blanking and an edit-mode blink are also
//               provided.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   REFRESH_DIV  : clk cycles per digit slot (>= 2)
//   BLINK_FRAMES : full 4-digit frames per blink half-period (>= 1)
// Ports
//   clk                       : system clock, all state on rising edge
//   rst_n                     : synchronous reset, active-low
//   sec1, sec2, min1, min2    : display-A digits (sec ones/tens, min ones/tens)
//   sec11, sec22, min11, min22: display-B digits, same ordering
//   sel                       : 0 = show display A, 1 = show display B
//   flash                     : 1 = edit mode, display blinks
//   lz_en                     : 1 = blank minutes-tens digit when it is 0
//   seg[6:0]                  : cathodes {g,f,e,d,c,b,a}, active-low
//   dp                        : decimal point, active-low
//   an[3:0]                   : anodes, active-low, an[0] = rightmost digit
// ============================================================================
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec1,
    input  logic [3:0] sec2,
    input  logic [3:0] min1,
    input  logic [3:0] min2,
    input  logic [3:0] sec11,
    input  logic [3:0] sec22,
    input  logic [3:0] min11,
    input  logic [3:0] min22,
    input  logic       sel,
    input  logic       flash,
    input  logic       lz_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PW = $clog2(REFRESH_DIV);
    localparam int c_FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(REFRESH_DIV - 1);
    localparam logic [c_FW-1:0] c_FCNT_MAX  = c_FW'(BLINK_FRAMES - 1);

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
    localparam logic [3:0] c_AN_OFF    = 4'b1111;

    localparam logic [1:0] c_SLOT_SEC  = 2'd0;
    localparam logic [1:0] c_SLOT_DP   = 2'd2;
    localparam logic [1:0] c_SLOT_MINT = 2'd3;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [c_PW-1:0]  r_presc;
    logic             w_tick;

    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;
    logic             w_frame_end;

    // Both digit sets are captured at the frame boundary; r_snap_sel records
    // which one the frame belongs to, so the pair behaves as a snapshot of the
    // selected set together with the selection itself.
    logic [3:0][3:0]  r_snap_a;
    logic [3:0][3:0]  r_snap_b;
    logic             r_snap_sel;
    logic [3:0][3:0]  w_snap;

    logic [c_FW-1:0]  r_fcnt;
    logic [c_FW-1:0]  w_fcnt_next;
    logic             r_phase_on;
    logic             w_phase_next;

    logic [3:0]       w_live_sec;
    logic [3:0]       w_digit;
    logic             w_lz_blank;
    logic             w_blank;

    logic [6:0]       w_seg_next;
    logic             w_dp_next;
    logic [3:0]       w_an_next;

    logic [6:0]       r_seg;
    logic             r_dp;
    logic [3:0]       r_an;

    // ------------------------------------------------------------------------
    // Digit decoder: BCD value to active-low {g,f,e,d,c,b,a}.
    // Values above 9 cannot be shown as a digit and render as a dash.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = c_SEG_DASH;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Refresh prescaler: counts 0..REFRESH_DIV-1, the wrap cycle is a tick
    // ------------------------------------------------------------------------
    assign w_tick = (r_presc == c_PRESC_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Slot index: advances mod 4 on every tick
    // ------------------------------------------------------------------------
    assign w_idx_next  = r_idx + 2'd1;
    assign w_frame_end = w_tick && (r_idx == c_SLOT_MINT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_idx <= w_idx_next;
        end
    end

    // ------------------------------------------------------------------------
    // Frame snapshot, taken on the tick that leaves the last slot
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap_a   <= '0;
            r_snap_b   <= '0;
            r_snap_sel <= 1'b0;
        end else if (w_frame_end) begin
            r_snap_a   <= {min2, min1, sec2, sec1};
            r_snap_b   <= {min22, min11, sec22, sec11};
            r_snap_sel <= sel;
        end
    end

    // ------------------------------------------------------------------------
    // Blink control. The counter counts frames completed while flash is held
    // and toggles the phase every BLINK_FRAMES frames. Dropping flash takes
    // effect on the very next clock so the display never stays dark after
    // leaving edit mode. The phase decided for the upcoming slot is used for
    // that slot's outputs, so a toggle lines up with the start of a frame.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fcnt_next  = r_fcnt;
        w_phase_next = r_phase_on;
        if (!flash) begin
            w_fcnt_next  = '0;
            w_phase_next = 1'b1;
        end else if (w_frame_end) begin
            if (r_fcnt == c_FCNT_MAX) begin
                w_fcnt_next  = '0;
                w_phase_next = ~r_phase_on;
            end else begin
                w_fcnt_next  = r_fcnt + c_FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fcnt     <= '0;
            r_phase_on <= 1'b1;
        end else begin
            r_fcnt     <= w_fcnt_next;
            r_phase_on <= w_phase_next;
        end
    end

    // ------------------------------------------------------------------------
    // Digit selection for the upcoming slot. Slot 0 opens a new frame and is
    // taken from the live inputs sampled on the same tick as the snapshot, so
    // it agrees with the snapshot the rest of the frame will use.
    // ------------------------------------------------------------------------
    assign w_live_sec = sel ? sec11 : sec1;

    always_comb begin
        w_snap  = r_snap_sel ? r_snap_b : r_snap_a;
        w_digit = w_snap[w_idx_next];
        if (w_idx_next == c_SLOT_SEC) begin
            w_digit = w_live_sec;
        end
    end

    // ------------------------------------------------------------------------
    // Next output values. Blanking (leading zero or blink-off) turns every
    // anode off and also clears the cathodes and decimal point so no ghost
    // segment is driven while the digit is dark.
    // ------------------------------------------------------------------------
    assign w_lz_blank = lz_en && (w_idx_next == c_SLOT_MINT) && (w_digit == 4'd0);
    assign w_blank    = w_lz_blank || !w_phase_next;

    always_comb begin
        w_an_next  = ~(4'b0001 << w_idx_next);
        w_seg_next = f_decode(w_digit);
        w_dp_next  = (w_idx_next != c_SLOT_DP);
        if (w_blank) begin
            w_an_next  = c_AN_OFF;
            w_seg_next = c_SEG_BLANK;
            w_dp_next  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: only move on ticks so the display is glitch-free
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= c_AN_OFF;
            r_seg <= c_SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_tick) begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver with REFRESH_DIV=4 and
//               BLINK_FRAMES=2. Each tick's expected outputs are pushed to a
//               scoreboard queue as stimulus is applied and popped when the
//               tick is sampled; outputs are also checked to hold between
//               ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int REFRESH_DIV  = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int N_TBL        = 35;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sec1, sec2, min1, min2;
    logic [3:0] sec11, sec22, min11, min22;
    logic       sel   = 1'b0;
    logic       flash = 1'b0;
    logic       lz_en = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sec1  (sec1),
        .sec2  (sec2),
        .min1  (min1),
        .min2  (min2),
        .sec11 (sec11),
        .sec22 (sec22),
        .min11 (min11),
        .min22 (min22),
        .sel   (sel),
        .flash (flash),
        .lz_en (lz_en),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    // One table row: inputs applied before a tick and the slot/value that
    // tick must show (or blank).
    typedef struct {
        logic        sel;
        logic        lz;
        logic [15:0] da;   // {min2, min1, sec2, sec1}
        logic [15:0] db;   // {min22, min11, sec22, sec11}
        int          slot;
        int          val;
        bit          blank;
    } vec_t;

    vec_t tbl [N_TBL];
    out_t sb_q[$];
    out_t held;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [6:0] seg_code(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic out_t vis(input int slot, input int v);
        out_t o;
        o.an       = 4'hF;
        o.an[slot] = 1'b0;
        o.seg      = seg_code(v);
        o.dp       = (slot == 2) ? 1'b0 : 1'b1;
        return o;
    endfunction

    function automatic out_t blank_out();
        out_t o;
        o.an  = 4'hF;
        o.seg = 7'h7F;
        o.dp  = 1'b1;
        return o;
    endfunction

    function automatic vec_t mk(input logic s, input logic l, input logic [15:0] a,
                                input logic [15:0] b, input int slot, input int val,
                                input bit bl);
        vec_t v;
        v.sel = s; v.lz = l; v.da = a; v.db = b;
        v.slot = slot; v.val = val; v.blank = bl;
        return v;
    endfunction

    // Digits while blinking: {min2,min1,sec2,sec1} = {0,2,10,12}
    function automatic int blink_val(input int slot);
        return (slot == 0) ? 12 : (slot == 1) ? 10 : (slot == 2) ? 2 : 0;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = {an, seg, dp};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
        end
        n_checks++;
        if ($countones(~an) > 1) begin
            n_fail++;
            $display("FAIL %s one-anode: an=%b, expected at most one low bit", name, an);
        end
    endtask

    // Runs one slot period: the first REFRESH_DIV-1 clocks must hold the
    // previous outputs, the last clock is the tick and is compared against
    // the scoreboard head.
    task automatic run_slot(input string name);
        out_t exp;
        for (int i = 0; i < REFRESH_DIV; i++) begin
            @(posedge clk);
            #1;
            if (i < REFRESH_DIV - 1) begin
                check({name, " hold"}, held);
            end else if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: scoreboard empty, expected an entry", name);
            end else begin
                exp = sb_q.pop_front();
                check(name, exp);
                held = exp;
            end
        end
    endtask

    task automatic apply(input vec_t v);
        sel = v.sel;
        lz_en = v.lz;
        {min2, min1, sec2, sec1}     = v.da;
        {min22, min11, sec22, sec11} = v.db;
    endtask

    // Ticks 36..73: blink with flash raised mid-frame, drop while dark,
    // re-raise until the display goes dark again.
    task automatic run_blink();
        int  f;
        bit  on;
        for (int t = 36; t <= 65; t++) begin
            if (t == 37) flash = 1'b1;
            f  = t / 4;
            on = (f < 10) || ((((f - 9) / 2) % 2) == 0);
            sb_q.push_back(on ? vis(t % 4, blink_val(t % 4)) : blank_out());
            run_slot($sformatf("blink T%0d", t));
        end
        // Still dark (frame 16); releasing flash must show the next slot.
        flash = 1'b0;
        sb_q.push_back(vis(2, blink_val(2)));
        run_slot("flash drop T66");
        sb_q.push_back(vis(3, blink_val(3)));
        run_slot("flash drop T67");
        flash = 1'b1;
        for (int t = 68; t <= 73; t++) begin
            sb_q.push_back((t < 72) ? vis(t % 4, blink_val(t % 4)) : blank_out());
            run_slot($sformatf("reblink T%0d", t));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        // Rows are ticks T1..T35 after reset release.
        tbl[0]  = mk(0, 0, 16'h1234, 16'h5678, 1, 0, 0);
        tbl[1]  = mk(0, 0, 16'h1234, 16'h5678, 2, 0, 0);
        tbl[2]  = mk(0, 0, 16'h1234, 16'h5678, 3, 0, 0);
        tbl[3]  = mk(0, 0, 16'h1234, 16'h5678, 0, 4, 0);
        tbl[4]  = mk(0, 0, 16'h1234, 16'h5678, 1, 3, 0);
        tbl[5]  = mk(0, 0, 16'h1234, 16'h5678, 2, 2, 0);
        tbl[6]  = mk(0, 0, 16'h1234, 16'h5678, 3, 1, 0);
        tbl[7]  = mk(0, 0, 16'h1234, 16'h5678, 0, 4, 0);
        tbl[8]  = mk(0, 0, 16'h1234, 16'h5678, 1, 3, 0);
        tbl[9]  = mk(0, 0, 16'h1234, 16'h5678, 2, 2, 0);
        tbl[10] = mk(0, 0, 16'h1234, 16'h5678, 3, 1, 0);
        // min2=0 with leading-zero blanking
        tbl[11] = mk(0, 1, 16'h0234, 16'h5678, 0, 4, 0);
        tbl[12] = mk(0, 1, 16'h0234, 16'h5678, 1, 3, 0);
        tbl[13] = mk(0, 1, 16'h0234, 16'h5678, 2, 2, 0);
        tbl[14] = mk(0, 1, 16'h0234, 16'h5678, 3, 0, 1);
        tbl[15] = mk(0, 0, 16'h0234, 16'h5678, 0, 4, 0);
        tbl[16] = mk(0, 0, 16'h0234, 16'h5678, 1, 3, 0);
        // sel flips while index=1: rest of frame stays on A
        tbl[17] = mk(1, 0, 16'h0234, 16'h5678, 2, 2, 0);
        tbl[18] = mk(1, 0, 16'h0234, 16'h5678, 3, 0, 0);
        tbl[19] = mk(1, 0, 16'h0234, 16'h5678, 0, 8, 0);
        // sec22 changes mid-frame: no tearing
        tbl[20] = mk(1, 0, 16'h0234, 16'h5698, 1, 7, 0);
        tbl[21] = mk(1, 0, 16'h0234, 16'h5698, 2, 6, 0);
        tbl[22] = mk(1, 0, 16'h0234, 16'h5698, 3, 5, 0);
        tbl[23] = mk(1, 0, 16'h0234, 16'h5698, 0, 8, 0);
        tbl[24] = mk(1, 0, 16'h0234, 16'h5698, 1, 9, 0);
        tbl[25] = mk(1, 0, 16'h0234, 16'h5698, 2, 6, 0);
        // back to A with sec1=12 (dash)
        tbl[26] = mk(0, 0, 16'h023C, 16'h5698, 3, 5, 0);
        tbl[27] = mk(0, 0, 16'h023C, 16'h5698, 0, 12, 0);
        tbl[28] = mk(0, 0, 16'h023C, 16'h5698, 1, 3, 0);
        tbl[29] = mk(0, 0, 16'h023C, 16'h5698, 2, 2, 0);
        tbl[30] = mk(0, 0, 16'h023C, 16'h5698, 3, 0, 0);
        tbl[31] = mk(0, 0, 16'h02AC, 16'h5698, 0, 12, 0);
        tbl[32] = mk(0, 0, 16'h02AC, 16'h5698, 1, 10, 0);
        tbl[33] = mk(0, 0, 16'h02AC, 16'h5698, 2, 2, 0);
        tbl[34] = mk(0, 0, 16'h02AC, 16'h5698, 3, 0, 0);

        apply(tbl[0]);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", blank_out());
        held  = blank_out();
        rst_n = 1'b1;

        for (int t = 0; t < N_TBL; t++) begin
            apply(tbl[t]);
            sb_q.push_back(tbl[t].blank ? blank_out() : vis(tbl[t].slot, tbl[t].val));
            run_slot($sformatf("scan T%0d", t + 1));
        end

        run_blink();

        // One-clock reset pulse while dark in mid-frame
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset pulse", blank_out());
        held  = blank_out();
        rst_n = 1'b1;
        sb_q.push_back(vis(1, 0));
        run_slot("post-reset T1");
        sb_q.push_back(vis(2, 0));
        run_slot("post-reset T2");
        sb_q.push_back(vis(3, 0));
        run_slot("post-reset T3");
        sb_q.push_back(vis(0, 12));
        run_slot("post-reset T4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001: Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2 or more.
REQ-002: Parameter BLINK_FRAMES, default 125, full 4-digit frames per blink half-period; legal range 1 or more.
REQ-003: clk  input  1  system clock; single clock domain, all state on its rising edge.
REQ-004: rst_n  input  1  reset, synchronous, active-low.
REQ-005: sec1, sec2, min1, min2  input  4 each  display-A digits (seconds ones/tens, minutes ones/tens).
REQ-006: sec11, sec22, min11, min22  input  4 each  display-B digits, same ordering.
REQ-007: sel  input  1  0 shows display A, 1 shows display B.
REQ-008: flash  input  1  1 means edit mode, the display blinks.
REQ-009: lz_en  input  1  1 means blank the minutes-tens digit when it is 0.
REQ-010: seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low; seg[0] is segment a.
REQ-011: dp  output  1  decimal point, active-low.
REQ-012: an  output  4  anodes, active-low; an[0] is the rightmost digit.

Function
REQ-013: The prescaler SHALL count 0 to REFRESH_DIV-1 and wrap; the wrap cycle is a "tick".
REQ-014: On each tick, a 2-bit index SHALL advance mod 4; index 0 maps to an[0]/sec, 1 to an[1]/sec-tens, 2 to an[2]/min, 3 to an[3]/min-tens.
REQ-015: seg, dp and an SHALL be registered and update only on ticks, one clk after the index change is decided; no output changes between ticks.
REQ-016: Frame snapshot: on a tick with current index 3, the block SHALL latch all four digits of the set chosen by sel, and latch sel itself.
  - Slot 0 of the new frame uses the live inputs sampled on that same tick.
  - Slots 1-3 use the snapshot; mid-frame input or sel changes SHALL NOT tear a frame.
REQ-017: Decode values 0-9 (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10-15 SHALL show a dash, 0111111.
REQ-018: dp SHALL be 0 only in slot 2 (separates minutes and seconds), otherwise 1; blanking per REQ-019/020 also forces dp=1.
REQ-019: Leading-zero blanking: slot 3 with lz_en=1 and digit value 0 SHALL drive an=1111 and seg=1111111 for that slot.
REQ-020: Blink: a frame counter SHALL count completed frames (ticks leaving index 3) while flash=1.
  - At BLINK_FRAMES frames the phase SHALL toggle and the counter clears.
  - Phase off: an=1111 in every slot.
  - Phase on: normal scan.
REQ-021: flash=0 SHALL clear the frame counter and force phase on within the same clk; the display is visible on the next tick.
REQ-022: Exactly one anode bit SHALL be 0 in any unblanked slot; never more than one.
REQ-023: If flash rises on a tick cycle, both effects SHALL apply in that cycle: the tick advances the index and the counter starts at 0.

Reset
REQ-024: While rst_n=0 at a clk edge, the block SHALL set:
  - prescaler, index and frame counter to 0
  - blink phase on, snapshot digits and snapshot sel to 0
  - an=1111, seg=1111111, dp=1
REQ-025: After reset release, outputs SHALL stay blank until the first tick (REFRESH_DIV cycles later), which drives slot 1 from the zero snapshot.
REQ-026: Reset asserted mid-frame or mid-blink SHALL abort the frame; no partial state survives.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-027: Reset, then sel=0, min2..sec1=1,2,3,4, lz_en=0, flash=0; run 3 frames.
  - Frames 2-3 show an sequence 1110/1101/1011/0111, each held 4 clks.
  - seg = 4, 3, 2, 1 codes respectively.
  - dp=0 only with an=1011.
REQ-028: min2=0, lz_en=1 -> slot 3 drives an=1111; lz_en=0 -> slot 3 shows 1000000.
REQ-029: Toggle sel 0->1 while index=1 -> remaining slots of that frame stay on set A; set B appears from the next slot 0.
REQ-030: flash=1 for 8 frames -> pattern of 2 frames visible, 2 blank, repeating. Drop flash while blank -> next tick visible.
REQ-031: Digit value 12 on sec1 -> slot 0 shows 0111111.
REQ-032: Pulse rst_n=0 for 1 clk mid-frame during blink-off -> an=1111, seg=1111111, dp=1 the next cycle; first tick 4 clks after release drives an=1101.
